// File: rtl/fft_weight_loader_if.sv
// fft_weight_loader_if
//   Serial twiddle-weight beat bus between the weight driver and the loader.
//   Signals:
//     din_weight_valid  beat valid (no backpressure)
//     din_weight_real   weight real part, two's complement, WIDTH bits
//     din_weight_imag   weight imag part, two's complement, WIDTH bits
//     weight_flush      discard the partially received frame
//     weight_conj       conjugate on commit (only with FFT_WEIGHT_CONJ_EN)
//   Modports: master = weight driver, slave = fft_weight_loader.
interface fft_weight_loader_if #(
  parameter int WIDTH = 16
);
  logic             din_weight_valid;
  logic [WIDTH-1:0] din_weight_real;
  logic [WIDTH-1:0] din_weight_imag;
  logic             weight_flush;
`ifdef FFT_WEIGHT_CONJ_EN
  logic             weight_conj;

  modport master (output din_weight_valid, din_weight_real, din_weight_imag,
                  weight_flush, weight_conj);
  modport slave  (input  din_weight_valid, din_weight_real, din_weight_imag,
                  weight_flush, weight_conj);
`else
  modport master (output din_weight_valid, din_weight_real, din_weight_imag,
                  weight_flush);
  modport slave  (input  din_weight_valid, din_weight_real, din_weight_imag,
                  weight_flush);
`endif
endinterface

// File: rtl/fft_weight_loader.sv
// fft_weight_loader
//   Receives serial complex twiddle weights into a shadow bank and commits a
//   complete frame atomically to the active bank driving the butterflies.
//   Ports:
//     clk             clock
//     rst_n           synchronous active-low reset
//     wif             beat bus (slave modport of fft_weight_loader_if)
//     weight_real     active bank real parts, slot k at [k*WIDTH +: WIDTH]
//     weight_imag     active bank imag parts, same packing
//     weight_ready    at least one frame committed since reset
//     weight_commit   one-cycle pulse following a commit edge
//     weight_loading  shadow frame partially filled
//   Optional macro FFT_WEIGHT_CONJ_EN: adds wif.weight_conj; when high at the
//   commit edge all committed imag parts are negated with saturation.
//
//   state | meaning
//   IDLE  | no beats of the current frame received (idx == 0)
//   FILL  | frame partially received (idx != 0)
module fft_weight_loader #(
  parameter  int NPOINT = 3,
  parameter  int WIDTH  = 16,
  localparam int WNUM   = 1 << (NPOINT - 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_weight_loader_if.slave    wif,
  output logic [WIDTH*WNUM-1:0] weight_real,
  output logic [WIDTH*WNUM-1:0] weight_imag,
  output logic                  weight_ready,
  output logic                  weight_commit,
  output logic                  weight_loading
);

  localparam int            IW       = (NPOINT > 1) ? NPOINT - 1 : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WNUM - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sh_re [WNUM];
  logic [WIDTH-1:0] sh_im [WNUM];
  logic [WIDTH-1:0] c_re  [WNUM];
  logic [WIDTH-1:0] c_im  [WNUM];
  logic             accept, at_last, commit_now;

`ifdef FFT_WEIGHT_CONJ_EN
  // The most negative value has no positive counterpart; clamp to max.
  function automatic logic [WIDTH-1:0] conj_sat(input logic [WIDTH-1:0] x);
    if (x == {1'b1, {(WIDTH-1){1'b0}}})
      return {1'b0, {(WIDTH-1){1'b1}}};
    return -x;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !at_last) state_nxt = FILL;
      FILL: if (wif.weight_flush || commit_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    weight_loading = (state == FILL);
    // Flush dominates a coincident beat, including the final one.
    accept         = wif.din_weight_valid && !wif.weight_flush;
    at_last        = (idx == LAST_IDX);
    commit_now     = accept && at_last;
  end

  // Commit image: shadow slots with the final slot taken from the live beat.
  always_comb begin
    for (int k = 0; k < WNUM; k++) begin
      c_re[k] = sh_re[k];
      c_im[k] = sh_im[k];
    end
    c_re[WNUM-1] = wif.din_weight_real;
    c_im[WNUM-1] = wif.din_weight_imag;
`ifdef FFT_WEIGHT_CONJ_EN
    if (wif.weight_conj) begin
      for (int k = 0; k < WNUM; k++) c_im[k] = conj_sat(c_im[k]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      weight_commit <= 1'b0;
      weight_ready  <= 1'b0;
      weight_real   <= '0;
      weight_imag   <= '0;
      for (int k = 0; k < WNUM; k++) begin
        sh_re[k] <= '0;
        sh_im[k] <= '0;
      end
    end else begin
      weight_commit <= commit_now;
      if (wif.weight_flush)
        idx <= '0;
      else if (wif.din_weight_valid)
        idx <= at_last ? '0 : idx + 1'b1;
      if (accept) begin
        sh_re[idx] <= wif.din_weight_real;
        sh_im[idx] <= wif.din_weight_imag;
      end
      if (commit_now) begin
        weight_ready <= 1'b1;
        for (int k = 0; k < WNUM; k++) begin
          weight_real[k*WIDTH +: WIDTH] <= c_re[k];
          weight_imag[k*WIDTH +: WIDTH] <= c_im[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_weight_loader.sv
module tb_fft_weight_loader;
  localparam int NPOINT = 3;
  localparam int WIDTH  = 16;
  localparam int WNUM   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_weight_loader_if #(.WIDTH(WIDTH)) wif();
  logic [WIDTH*WNUM-1:0] weight_real, weight_imag;
  logic weight_ready, weight_commit, weight_loading;

  fft_weight_loader #(.NPOINT(NPOINT), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .wif(wif),
    .weight_real(weight_real), .weight_imag(weight_imag),
    .weight_ready(weight_ready), .weight_commit(weight_commit),
    .weight_loading(weight_loading)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: a frame is just the list of accepted beats.
  logic [15:0] q_re[$];
  logic [15:0] q_im[$];
  logic [15:0] m_re[WNUM];
  logic [15:0] m_im[WNUM];
  bit m_ready, m_commit;

  function automatic logic [15:0] neg_sat(logic [15:0] x);
    int v;
    v = $signed(x);
    v = -v;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [WIDTH*WNUM-1:0] exp_real();
    logic [WIDTH*WNUM-1:0] r;
    for (int k = 0; k < WNUM; k++) r[k*16 +: 16] = m_re[k];
    return r;
  endfunction

  function automatic logic [WIDTH*WNUM-1:0] exp_imag();
    logic [WIDTH*WNUM-1:0] r;
    for (int k = 0; k < WNUM; k++) r[k*16 +: 16] = m_im[k];
    return r;
  endfunction

  task automatic tick();
    bit cj;
    @(posedge clk);
    cj = 1'b0;
`ifdef FFT_WEIGHT_CONJ_EN
    cj = wif.weight_conj;
`endif
    if (!rst_n) begin
      q_re.delete(); q_im.delete();
      for (int k = 0; k < WNUM; k++) begin m_re[k] = '0; m_im[k] = '0; end
      m_ready = 0; m_commit = 0;
    end else begin
      m_commit = 0;
      if (wif.weight_flush) begin
        q_re.delete(); q_im.delete();
      end else if (wif.din_weight_valid) begin
        q_re.push_back(wif.din_weight_real);
        q_im.push_back(wif.din_weight_imag);
        if (q_re.size() == WNUM) begin
          for (int k = 0; k < WNUM; k++) begin
            m_re[k] = q_re[k];
            m_im[k] = cj ? neg_sat(q_im[k]) : q_im[k];
          end
          m_commit = 1; m_ready = 1;
          q_re.delete(); q_im.delete();
        end
      end
    end
    #1;
  endtask

  task automatic drive(bit v, logic [15:0] re, logic [15:0] im, bit fl);
    wif.din_weight_valid = v;
    wif.din_weight_real  = re;
    wif.din_weight_imag  = im;
    wif.weight_flush     = fl;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 0, 0);
    tick(); tick();
    n_checks++; if (weight_real !== '0) $display("FAIL reset_real got %h exp 0", weight_real); else n_pass++;
    n_checks++; if (weight_imag !== '0) $display("FAIL reset_imag got %h exp 0", weight_imag); else n_pass++;
    n_checks++; if ({weight_ready, weight_commit, weight_loading} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {weight_ready, weight_commit, weight_loading}); else n_pass++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    logic [WIDTH*WNUM-1:0] want;
    want = {16'd4096, 16'd3072, 16'd2048, 16'd1024};
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(1024 * (i + 1)), 0, 0);
      tick();
      if (i < 3) begin
        n_checks++; if (weight_commit !== 1'b0 || weight_loading !== 1'b1)
          $display("FAIL basic_mid%0d commit=%b loading=%b exp 0/1", i, weight_commit, weight_loading); else n_pass++;
      end
    end
    drive(0, 0, 0, 0);
    n_checks++; if (weight_real !== want) $display("FAIL basic_real got %h exp %h", weight_real, want); else n_pass++;
    n_checks++; if (weight_imag !== '0) $display("FAIL basic_imag got %h exp 0", weight_imag); else n_pass++;
    n_checks++; if ({weight_commit, weight_ready, weight_loading} !== 3'b110)
      $display("FAIL basic_flags got %b exp 110", {weight_commit, weight_ready, weight_loading}); else n_pass++;
    tick();
    n_checks++; if (weight_commit !== 1'b0) $display("FAIL basic_pulse got %b exp 0", weight_commit); else n_pass++;
  endtask

  task automatic test_gap();
    int vals[7] = '{1024, 2048, 0, 0, 0, 3072, 4096};
    for (int i = 0; i < 7; i++) begin
      drive(vals[i] != 0, 16'(vals[i]), 0, 0);
      tick();
      n_checks++; if (weight_loading !== (q_re.size() != 0) || weight_commit !== m_commit)
        $display("FAIL gap_c%0d loading=%b commit=%b exp %b/%b", i, weight_loading, weight_commit, q_re.size() != 0, m_commit); else n_pass++;
    end
    drive(0, 0, 0, 0);
    n_checks++; if (weight_real !== {16'd4096, 16'd3072, 16'd2048, 16'd1024} || weight_commit !== 1'b1)
      $display("FAIL gap_commit real=%h commit=%b", weight_real, weight_commit); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    int seq_re[11] = '{1, 2, 3, 4, 9, 10, -1, 5, 6, 7, 8};
    bit seen;
    for (int i = 0; i < 11; i++) begin
      if (seq_re[i] < 0) drive(0, 0, 0, 1);
      else drive(1, 16'(seq_re[i]), 16'($urandom), 0);
      tick();
      seen = 0;
      for (int k = 0; k < WNUM; k++)
        if (weight_real[k*16 +: 16] == 16'd9 || weight_real[k*16 +: 16] == 16'd10) seen = 1;
      n_checks++; if (weight_real !== exp_real() || seen)
        $display("FAIL flush_c%0d got %h exp %h", i, weight_real, exp_real()); else n_pass++;
    end
    drive(0, 0, 0, 0);
    n_checks++; if (weight_real !== {16'd8, 16'd7, 16'd6, 16'd5} || weight_imag !== exp_imag())
      $display("FAIL flush_final real=%h imag=%h exp %h", weight_real, weight_imag, exp_imag()); else n_pass++;
    tick();
  endtask

  task automatic test_flush_last();
    for (int i = 0; i < 3; i++) begin drive(1, 16'(11 + i), 0, 0); tick(); end
    drive(1, 16'd14, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    n_checks++; if (weight_commit !== 1'b0 || weight_loading !== 1'b0 || weight_real !== {16'd8, 16'd7, 16'd6, 16'd5})
      $display("FAIL flush_last commit=%b loading=%b real=%h", weight_commit, weight_loading, weight_real); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(21 + i), 0, 0);
      tick();
      n_checks++; if (weight_commit !== (i == 3))
        $display("FAIL flush_last_idx%0d commit=%b exp %b", i, weight_commit, i == 3); else n_pass++;
    end
    drive(0, 0, 0, 0);
    n_checks++; if (weight_real !== {16'd24, 16'd23, 16'd22, 16'd21})
      $display("FAIL flush_last_frame got %h", weight_real); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin drive(1, 16'(31 + i), 0, 0); tick(); end
    drive(0, 0, 0, 0);
    rst_n = 0; tick(); rst_n = 1;
    n_checks++; if (weight_ready !== 1'b0 || weight_real !== '0 || weight_loading !== 1'b0)
      $display("FAIL rstmid_clear ready=%b real=%h loading=%b", weight_ready, weight_real, weight_loading); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(41 + i), 16'(i), 0);
      tick();
      n_checks++; if (weight_ready !== (i == 3) || weight_commit !== (i == 3))
        $display("FAIL rstmid_b%0d ready=%b commit=%b exp %b", i, weight_ready, weight_commit, i == 3); else n_pass++;
    end
    drive(0, 0, 0, 0);
    n_checks++; if (weight_real !== {16'd44, 16'd43, 16'd42, 16'd41} || weight_imag !== {16'd3, 16'd2, 16'd1, 16'd0})
      $display("FAIL rstmid_frame real=%h imag=%h", weight_real, weight_imag); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 1); tick();
    for (int i = 0; i < 12; i++) begin
      drive(1, 16'($urandom), 16'($urandom), 0);
      tick();
      n_checks++; if (weight_commit !== ((i % 4) == 3) || weight_real !== exp_real() || weight_imag !== exp_imag())
        $display("FAIL b2b_c%0d commit=%b real=%h exp %h", i, weight_commit, weight_real, exp_real()); else n_pass++;
    end
    drive(0, 0, 0, 0); tick();
  endtask

`ifdef FFT_WEIGHT_CONJ_EN
  task automatic test_conj();
    logic [15:0] im[4] = '{16'd100, 16'h8000, 16'd0, 16'hFFFB};
    drive(0, 0, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      wif.weight_conj = (i == 3);
      drive(1, 16'(50 + i), im[i], 0);
      tick();
    end
    wif.weight_conj = 0;
    drive(0, 0, 0, 0);
    n_checks++; if (weight_imag !== {16'd5, 16'd0, 16'h7FFF, 16'hFF9C})
      $display("FAIL conj_imag got %h exp %h", weight_imag, {16'd5, 16'd0, 16'h7FFF, 16'hFF9C}); else n_pass++;
    n_checks++; if (weight_real !== {16'd53, 16'd52, 16'd51, 16'd50})
      $display("FAIL conj_real got %h", weight_real); else n_pass++;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), $urandom_range(0, 19) == 0);
`ifdef FFT_WEIGHT_CONJ_EN
      wif.weight_conj = $urandom_range(0, 1);
`endif
      tick();
      n_checks++; if (weight_real !== exp_real() || weight_imag !== exp_imag() || weight_commit !== m_commit ||
                      weight_ready !== m_ready || weight_loading !== (q_re.size() != 0))
        $display("FAIL rand_c%0d real=%h/%h imag=%h/%h c=%b/%b r=%b/%b l=%b/%b", i, weight_real, exp_real(),
                 weight_imag, exp_imag(), weight_commit, m_commit, weight_ready, m_ready, weight_loading, q_re.size() != 0);
      else n_pass++;
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
`ifdef FFT_WEIGHT_CONJ_EN
    wif.weight_conj = 0;
`endif
    test_reset();
    test_basic();
    test_gap();
    test_flush();
    test_flush_last();
    test_reset_mid();
    test_back_to_back();
`ifdef FFT_WEIGHT_CONJ_EN
    test_conj();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
